// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with arbitrary depth, occupancy count, almost-full/empty thresholds and sticky error flags.
// Compile-time option SYNC_FIFO_FWFT_EN selects first-word-fall-through read data; undefined gives registered read data.
module sync_fifo_param #(
   parameter int unsigned DATA_WIDTH      = 8,
   parameter int unsigned DEPTH           = 32,
   parameter int unsigned ALMOST_FULL_TH  = 28,
   parameter int unsigned ALMOST_EMPTY_TH = 4
) (
   input  logic                           i_clk,
   input  logic                           i_RST,
   input  logic [DATA_WIDTH-1:0]          i_wr_data,
   input  logic                           i_wr_en,
   output logic                           o_Full_Flag,
   output logic                           o_Almost_Full,
   input  logic                           i_rd_en,
   output logic [DATA_WIDTH-1:0]          o_rd_data,
   output logic                           o_Empty_Flag,
   output logic                           o_Almost_Empty,
   output logic [$clog2(DEPTH+1)-1:0]     o_Count,
   output logic                           o_Overflow,
   output logic                           o_Underflow
);

   localparam int unsigned ADDR_WIDTH = $clog2(DEPTH);
   localparam int unsigned CNT_WIDTH  = $clog2(DEPTH + 1);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic                  wr_acc;
   logic                  rd_acc;

   // Pointers wrap explicitly so any depth works, not only powers of two.
   function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
      return (p == ADDR_WIDTH'(DEPTH - 1)) ? '0 : p + ADDR_WIDTH'(1);
   endfunction

   assign wr_acc = i_wr_en & ~o_Full_Flag;
   assign rd_acc = i_rd_en & ~o_Empty_Flag;

   // All status flags decode from the registered count only.
   assign o_Full_Flag    = (o_Count == CNT_WIDTH'(DEPTH));
   assign o_Empty_Flag   = (o_Count == '0);
   assign o_Almost_Full  = (o_Count >= CNT_WIDTH'(ALMOST_FULL_TH));
   assign o_Almost_Empty = (o_Count <= CNT_WIDTH'(ALMOST_EMPTY_TH));

   always_ff @(posedge i_clk) begin
      if (i_RST) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         o_Count     <= '0;
         o_Overflow  <= 1'b0;
         o_Underflow <= 1'b0;
      end else begin
         if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
         if (rd_acc) rd_ptr <= ptr_inc(rd_ptr);
         if (wr_acc && !rd_acc)
            o_Count <= o_Count + CNT_WIDTH'(1);
         else if (rd_acc && !wr_acc)
            o_Count <= o_Count - CNT_WIDTH'(1);
         if (i_wr_en && o_Full_Flag)  o_Overflow  <= 1'b1;
         if (i_rd_en && o_Empty_Flag) o_Underflow <= 1'b1;
      end
   end

   // Storage is never cleared; reset only blocks the write.
   always_ff @(posedge i_clk) begin
      if (!i_RST && wr_acc) mem[wr_ptr] <= i_wr_data;
   end

`ifdef SYNC_FIFO_FWFT_EN
   assign o_rd_data = mem[rd_ptr];
`else
   always_ff @(posedge i_clk) begin
      if (i_RST)
         o_rd_data <= '0;
      else if (rd_acc)
         o_rd_data <= mem[rd_ptr];
   end
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param: two instances (depth 32 and depth 5) share stimulus and are
// compared every cycle against a list-based reference model, plus directed vectors and corner sequences.
module tb_sync_fifo_param;

   localparam int DEP_A = 32, AF_A = 28, AE_A = 4;
   localparam int DEP_B = 5,  AF_B = 4,  AE_B = 1;
   localparam int CW_A  = $clog2(DEP_A + 1);
   localparam int CW_B  = $clog2(DEP_B + 1);

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, wr_en, rd_en;
   logic [7:0] wr_data;

   logic            a_full, a_afull, a_empty, a_aempty, a_ovf, a_unf;
   logic [7:0]      a_rd;
   logic [CW_A-1:0] a_count;
   logic            b_full, b_afull, b_empty, b_aempty, b_ovf, b_unf;
   logic [7:0]      b_rd;
   logic [CW_B-1:0] b_count;

   sync_fifo_param #(.DATA_WIDTH(8), .DEPTH(DEP_A), .ALMOST_FULL_TH(AF_A), .ALMOST_EMPTY_TH(AE_A)) u_dut_a (
      .i_clk(clk), .i_RST(rst), .i_wr_data(wr_data), .i_wr_en(wr_en),
      .o_Full_Flag(a_full), .o_Almost_Full(a_afull), .i_rd_en(rd_en), .o_rd_data(a_rd),
      .o_Empty_Flag(a_empty), .o_Almost_Empty(a_aempty), .o_Count(a_count),
      .o_Overflow(a_ovf), .o_Underflow(a_unf));

   sync_fifo_param #(.DATA_WIDTH(8), .DEPTH(DEP_B), .ALMOST_FULL_TH(AF_B), .ALMOST_EMPTY_TH(AE_B)) u_dut_b (
      .i_clk(clk), .i_RST(rst), .i_wr_data(wr_data), .i_wr_en(wr_en),
      .o_Full_Flag(b_full), .o_Almost_Full(b_afull), .i_rd_en(rd_en), .o_rd_data(b_rd),
      .o_Empty_Flag(b_empty), .o_Almost_Empty(b_aempty), .o_Count(b_count),
      .o_Overflow(b_ovf), .o_Underflow(b_unf));

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: an ordered list per instance, head at index 0.
   logic [7:0] md [2][64];
   int         msize [2];
   logic       mo [2];
   logic       mu [2];
   logic [7:0] mrd [2];

   function automatic int dep_of(input int m);
      return (m == 0) ? DEP_A : DEP_B;
   endfunction
   function automatic int af_of(input int m);
      return (m == 0) ? AF_A : AF_B;
   endfunction
   function automatic int ae_of(input int m);
      return (m == 0) ? AE_A : AE_B;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d (0x%0h), expected %0d (0x%0h)", name, $time, act, act, exp, exp);
      end
   endtask

   task automatic model_edge(input logic r, input logic w, input logic rq, input logic [7:0] d);
      for (int m = 0; m < 2; m++) begin
         bit was_full, was_empty;
         was_full  = (msize[m] == dep_of(m));
         was_empty = (msize[m] == 0);
         if (r) begin
            msize[m] = 0; mo[m] = 1'b0; mu[m] = 1'b0; mrd[m] = 8'h00;
         end else begin
            if (w && was_full)  mo[m] = 1'b1;
            if (rq && was_empty) mu[m] = 1'b1;
            if (rq && !was_empty) begin
               mrd[m] = md[m][0];
               for (int i = 0; i < 63; i++) md[m][i] = md[m][i+1];
               msize[m]--;
            end
            if (w && !was_full) begin
               md[m][msize[m]] = d;
               msize[m]++;
            end
         end
      end
   endtask

   task automatic check_all();
      for (int m = 0; m < 2; m++) begin
         int cnt;
         logic f, af, e, ae, o, u;
         logic [7:0] rdv;
         string p;
         p   = (m == 0) ? "a_" : "b_";
         cnt = (m == 0) ? int'(a_count) : int'(b_count);
         f   = (m == 0) ? a_full   : b_full;
         af  = (m == 0) ? a_afull  : b_afull;
         e   = (m == 0) ? a_empty  : b_empty;
         ae  = (m == 0) ? a_aempty : b_aempty;
         o   = (m == 0) ? a_ovf    : b_ovf;
         u   = (m == 0) ? a_unf    : b_unf;
         rdv = (m == 0) ? a_rd     : b_rd;
         chk({p, "count"},     cnt,    msize[m]);
         chk({p, "full"},      int'(f),  int'(msize[m] == dep_of(m)));
         chk({p, "afull"},     int'(af), int'(msize[m] >= af_of(m)));
         chk({p, "empty"},     int'(e),  int'(msize[m] == 0));
         chk({p, "aempty"},    int'(ae), int'(msize[m] <= ae_of(m)));
         chk({p, "overflow"},  int'(o),  int'(mo[m]));
         chk({p, "underflow"}, int'(u),  int'(mu[m]));
`ifdef SYNC_FIFO_FWFT_EN
         if (msize[m] > 0) chk({p, "rd_data"}, int'(rdv), int'(md[m][0]));
`else
         chk({p, "rd_data"}, int'(rdv), int'(mrd[m]));
`endif
      end
   endtask

   // One clock: drive inputs, advance model on the edge, sample 1 time unit later.
   task automatic step(input logic r, input logic w, input logic rq, input logic [7:0] d);
      rst = r; wr_en = w; rd_en = rq; wr_data = d;
      @(posedge clk);
      model_edge(r, w, rq, d);
      #1;
      check_all();
   endtask

   task automatic wr_n(input int n, input logic [7:0] base);
      for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, base + 8'(i));
   endtask

   task automatic rd_n(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, 8'h00);
   endtask

   typedef struct {
      logic       r, w, rq;
      logic [7:0] d;
      int         cnt;
      logic       emp, ful;
      logic [7:0] rd_std, rd_fw;
      logic       fw_chk;
   } vec_t;

   vec_t tbl [12];

   initial begin
      rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = 8'h00;
      for (int m = 0; m < 2; m++) begin
         msize[m] = 0; mo[m] = 1'b0; mu[m] = 1'b0; mrd[m] = 8'h00;
      end

      // Write 0x01..0x05 then read five back; expectations for the depth-32 instance.
      tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0};
      tbl[1]  = '{1'b0, 1'b1, 1'b0, 8'h01, 1, 1'b0, 1'b0, 8'h00, 8'h01, 1'b1};
      tbl[2]  = '{1'b0, 1'b1, 1'b0, 8'h02, 2, 1'b0, 1'b0, 8'h00, 8'h01, 1'b1};
      tbl[3]  = '{1'b0, 1'b1, 1'b0, 8'h03, 3, 1'b0, 1'b0, 8'h00, 8'h01, 1'b1};
      tbl[4]  = '{1'b0, 1'b1, 1'b0, 8'h04, 4, 1'b0, 1'b0, 8'h00, 8'h01, 1'b1};
      tbl[5]  = '{1'b0, 1'b1, 1'b0, 8'h05, 5, 1'b0, 1'b0, 8'h00, 8'h01, 1'b1};
      tbl[6]  = '{1'b0, 1'b0, 1'b1, 8'h00, 4, 1'b0, 1'b0, 8'h01, 8'h02, 1'b1};
      tbl[7]  = '{1'b0, 1'b0, 1'b1, 8'h00, 3, 1'b0, 1'b0, 8'h02, 8'h03, 1'b1};
      tbl[8]  = '{1'b0, 1'b0, 1'b1, 8'h00, 2, 1'b0, 1'b0, 8'h03, 8'h04, 1'b1};
      tbl[9]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1, 1'b0, 1'b0, 8'h04, 8'h05, 1'b1};
      tbl[10] = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b0, 8'h05, 8'h00, 1'b0};
      tbl[11] = '{1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b1, 1'b0, 8'h05, 8'h00, 1'b0};

      @(negedge clk);
      for (int i = 0; i < 12; i++) begin
         step(tbl[i].r, tbl[i].w, tbl[i].rq, tbl[i].d);
         chk("vec_count", int'(a_count), tbl[i].cnt);
         chk("vec_empty", int'(a_empty), int'(tbl[i].emp));
         chk("vec_full",  int'(a_full),  int'(tbl[i].ful));
`ifdef SYNC_FIFO_FWFT_EN
         if (tbl[i].fw_chk) chk("vec_rd_data", int'(a_rd), int'(tbl[i].rd_fw));
`else
         chk("vec_rd_data", int'(a_rd), int'(tbl[i].rd_std));
`endif
      end

      // Depth-5 pointer wrap: write 5, read 3, write 3, read 5.
      step(1'b1, 1'b0, 1'b0, 8'h00);
      wr_n(5, 8'h10);
      chk("wrap_full_at_5", int'(b_full), 1);
      rd_n(3);
      chk("wrap_not_full_at_2", int'(b_full), 0);
      wr_n(3, 8'h15);
      chk("wrap_full_again", int'(b_full), 1);
      rd_n(5);
      chk("wrap_empty_end", int'(b_empty), 1);
`ifndef SYNC_FIFO_FWFT_EN
      chk("wrap_last_word", int'(b_rd), 8'h17);
`endif

      // Fill depth-32 instance, then simultaneous write+read while full.
      step(1'b1, 1'b0, 1'b0, 8'h00);
      wr_n(DEP_A, 8'h40);
      chk("fill_full", int'(a_full), 1);
      step(1'b0, 1'b1, 1'b1, 8'hEE);
      chk("full_both_count", int'(a_count), DEP_A - 1);
      chk("full_both_ovf", int'(a_ovf), 1);
      step(1'b0, 1'b0, 1'b0, 8'h00);
      step(1'b0, 1'b0, 1'b1, 8'h00);
      chk("ovf_sticky", int'(a_ovf), 1);

      // Simultaneous write+read while empty.
      step(1'b1, 1'b0, 1'b0, 8'h00);
      step(1'b0, 1'b1, 1'b1, 8'hAA);
      chk("empty_both_unf", int'(a_unf), 1);
      chk("empty_both_count", int'(a_count), 1);
`ifdef SYNC_FIFO_FWFT_EN
      chk("empty_both_head", int'(a_rd), 8'hAA);
`endif
      rd_n(1);
`ifndef SYNC_FIFO_FWFT_EN
      chk("empty_both_read", int'(a_rd), 8'hAA);
`endif
      chk("empty_both_drained", int'(a_count), 0);

      // Almost thresholds on the depth-32 instance.
      step(1'b1, 1'b0, 1'b0, 8'h00);
      wr_n(4, 8'h60);
      chk("aempty_at_4", int'(a_aempty), 1);
      wr_n(1, 8'h64);
      chk("aempty_at_5", int'(a_aempty), 0);
      wr_n(22, 8'h65);
      chk("afull_at_27", int'(a_afull), 0);
      wr_n(1, 8'h7B);
      chk("afull_at_28", int'(a_afull), 1);
      rd_n(1);
      chk("afull_back_27", int'(a_afull), 0);

      // Reset at count 10 with a concurrent write.
      step(1'b1, 1'b0, 1'b0, 8'h00);
      step(1'b0, 1'b0, 1'b1, 8'h00);
      wr_n(10, 8'h80);
      chk("pre_reset_count", int'(a_count), 10);
      step(1'b1, 1'b1, 1'b0, 8'h55);
      chk("rst_count", int'(a_count), 0);
      chk("rst_empty", int'(a_empty), 1);
      chk("rst_ovf", int'(a_ovf), 0);
      chk("rst_unf", int'(a_unf), 0);
      chk("rst_b_ovf", int'(b_ovf), 0);

      // Randomized traffic in phases biased towards filling, draining and balanced.
      for (int c = 0; c < 4000; c++) begin
         int ph, pw, pr;
         logic r, w, rq;
         ph = (c / 150) % 3;
         pw = (ph == 0) ? 80 : (ph == 1) ? 30 : 50;
         pr = (ph == 0) ? 30 : (ph == 1) ? 80 : 50;
         r  = ($urandom_range(0, 299) == 0);
         w  = ($urandom_range(0, 99) < pw);
         rq = ($urandom_range(0, 99) < pr);
         step(r, w, rq, 8'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Single-clock, parametrised FIFO for same-domain buffering. It generalises the dual-clock FIFO into a one-clock block with these additions:
- arbitrary (non-power-of-two) depth
- an occupancy count
- programmable almost-full and almost-empty thresholds
- sticky overflow and underflow error flags
- a compile-time first-word-fall-through read mode

It sits between producer and consumer stages that share one clock, where no Gray-code pointer synchronisation is needed.

## Interface
Parameters:
- DATA_WIDTH, 8, width of each stored word.
- DEPTH, 32, number of words; any integer ≥ 2.
- ALMOST_FULL_TH, 28, occupancy at or above which o_Almost_Full asserts; range 1..DEPTH.
- ALMOST_EMPTY_TH, 4, occupancy at or below which o_Almost_Empty asserts; range 0..DEPTH-1.
- Localparams: ADDR_WIDTH = $clog2(DEPTH); CNT_WIDTH = $clog2(DEPTH+1).

Ports:
- i_clk  in  1  sole clock; all state changes on the rising edge.
- i_RST  in  1  reset. **Synchronous, active-high.**
- i_wr_data  in  DATA_WIDTH  write word.
- i_wr_en  in  1  write request.
- o_Full_Flag  out  1  occupancy == DEPTH.
- o_Almost_Full  out  1  occupancy ≥ ALMOST_FULL_TH.
- i_rd_en  in  1  read request.
- o_rd_data  out  DATA_WIDTH  read word.
- o_Empty_Flag  out  1  occupancy == 0.
- o_Almost_Empty  out  1  occupancy ≤ ALMOST_EMPTY_TH.
- o_Count  out  CNT_WIDTH  current occupancy, 0..DEPTH.
- o_Overflow  out  1  sticky: a write was attempted while full.
- o_Underflow  out  1  sticky: a read was attempted while empty.

## Operation
- Write accept: wr_acc = i_wr_en & ~o_Full_Flag. On accept, store at wr_ptr, then advance wr_ptr.
- Read accept: rd_acc = i_rd_en & ~o_Empty_Flag. On accept, advance rd_ptr.
- Pointers are ADDR_WIDTH wide and wrap explicitly from DEPTH-1 to 0. There is no reliance on power-of-two rollover.
- Count update, all in CNT_WIDTH arithmetic with no wrap:
  - +1 on wr_acc only.
  - -1 on rd_acc only.
  - Unchanged when both are accepted or neither is.
- All flags decode combinationally from the registered count. No flag depends on i_wr_en or i_rd_en in the same cycle.
- Simultaneous requests:
  - While full: the read is accepted, the write is rejected, and o_Overflow sets.
  - While empty: the write is accepted, the read is rejected, and o_Underflow sets.
  - Otherwise both are accepted and the count is unchanged.
- o_Overflow sets on i_wr_en & o_Full_Flag. o_Underflow sets on i_rd_en & o_Empty_Flag. Both clear only on reset.
- Rejected requests never modify the memory, the pointers or the count.
- Reset values (also apply on reset mid-operation; reset overrides any same-cycle request):
  - wr_ptr, rd_ptr, o_Count = 0.
  - o_Empty_Flag = 1, o_Almost_Empty = 1.
  - o_Full_Flag = 0, o_Almost_Full = 0.
  - o_Overflow = 0, o_Underflow = 0.
  - o_rd_data = 0 in standard mode.
  - Memory contents are not cleared.

## Timing
- Write accepted at edge k: o_Count, o_Empty_Flag and the other flags reflect it after edge k.
- Full assertion: o_Full_Flag is high in the cycle after the DEPTH-th net write, and the next write is rejected.
- Standard mode: o_rd_data is registered and presents the popped word after the accepting edge (1-cycle latency). It holds its value when no read is accepted.
- Write-to-read: a word written at edge k can be read-accepted at edge k+1 at the earliest.
- FWFT mode: timing is described under Configuration.

## Configuration
- Macro: SYNC_FIFO_FWFT_EN.
- Undefined (standard mode):
  - o_rd_data is a register loaded with mem[rd_ptr] on rd_acc.
  - It resets to 0.
- Defined (first-word-fall-through mode):
  - o_rd_data = mem[rd_ptr] combinationally, so the head word is visible whenever o_Empty_Flag = 0.
  - rd_acc pops the head, and the next word appears in the following cycle.
  - A word written at edge k is visible at o_rd_data after edge k.
  - o_rd_data is don't-care while empty.
- Flags, count and accept rules are identical in both modes.

## Test plan
- Reset, then write 0x01..0x05, then read 5 → data 0x01..0x05 in order; o_Count goes 5→0; o_Empty_Flag=1 at end. Both modes.
- DEPTH=5: write 5, read 3, write 3, read 5 → pointer wrap across index 4→0; data order preserved; o_Full_Flag high only at count 5.
- Fill to DEPTH, then assert i_wr_en & i_rd_en together → read accepted, write rejected, o_Count=DEPTH-1, o_Overflow=1 and sticky.
- Read while empty with a simultaneous write of 0xAA → o_Underflow=1, o_Count=1; the following read returns 0xAA.
- ALMOST_FULL_TH=28, ALMOST_EMPTY_TH=4 → o_Almost_Empty drops at count 5; o_Almost_Full rises at count 28 and falls at 27.
- Assert i_RST at count 10 together with i_wr_en → after the edge: o_Count=0, o_Empty_Flag=1, error flags 0; the write is ignored.
